sine_unit_arbiter: RTL and testbench

//  Shares one 3-stage pipelined PWL sine unit between N_REQ requesters, such as QFT phase-rotation lanes.
//  - Arbitration: round-robin, at most one issue per cycle.
//  - Tags every issue with the requester id and tracks it through the unit's fixed latency.
//  - Results land in a response FIFO with valid/ready backpressure.
//  - The sine unit cannot stall, so issue is credit-gated so the FIFO can never overflow.

---
 rtl/sine_unit_arbiter_if.sv | 31 +++
 rtl/sine_unit_arbiter.sv | 138 +++++++++++++
 tb/tb_sine_unit_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sine_unit_arbiter_if.sv
// sine_unit_arbiter_if: request, sine-unit and response signals of the shared sine unit arbiter
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

interface sine_unit_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int TW    = `TOTAL_WIDTH
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*TW-1:0] req_x;
   logic [N_REQ-1:0]    req_ready;
   logic [TW-1:0]       sin_x;
   logic [TW-1:0]       sin_y;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [ID_W-1:0]     rsp_id;
   logic [TW-1:0]       rsp_y;
   logic                busy;

   modport master (
      output req_valid, req_x, sin_y, rsp_ready,
      input  req_ready, sin_x, rsp_valid, rsp_id, rsp_y, busy
   );

   modport slave (
      input  req_valid, req_x, sin_y, rsp_ready,
      output req_ready, sin_x, rsp_valid, rsp_id, rsp_y, busy
   );
endinterface

// File: rtl/sine_unit_arbiter.sv
// sine_unit_arbiter: round-robin, credit-gated sharing of one fixed-latency sine unit; SINE_ARB_STATS_EN adds usage counters
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module sine_unit_arbiter #(
   parameter int N_REQ      = 4,
   parameter int ID_W       = 2,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int TW         = `TOTAL_WIDTH
) (
   input logic clk,
   input logic rst_n,
   sine_unit_arbiter_if.slave bus
`ifdef SINE_ARB_STATS_EN
   ,
   output logic [31:0] stat_issued,
   output logic [31:0] stat_stall
`endif
);
   localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + LAT + 1) + 1;

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] g_lo;
   logic [ID_W-1:0] g_hi;
   logic            any_valid;
   logic            any_hi;
   logic            credit_ok;
   logic            issue;
   logic            push;
   logic            pop;
   logic [TW-1:0]   sel_x;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   fifo_count;
   logic            tag_v  [LAT];
   logic [ID_W-1:0] tag_id [LAT];
   logic [ID_W-1:0] mem_id [FIFO_DEPTH];
   logic [TW-1:0]   mem_y  [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // credit counts only registered occupancy, so a pop this cycle frees a slot next cycle
   assign credit_ok     = (inflight + fifo_count) < CW'(FIFO_DEPTH);
   assign issue         = any_valid & credit_ok;
   assign push          = tag_v[LAT-1];
   assign bus.rsp_valid = fifo_count != '0;
   assign pop           = bus.rsp_valid & bus.rsp_ready;
   assign bus.rsp_id    = bus.rsp_valid ? mem_id[rd_ptr] : '0;
   assign bus.rsp_y     = bus.rsp_valid ? mem_y[rd_ptr] : '0;
   assign bus.busy      = (inflight != '0) | bus.rsp_valid;
   assign bus.sin_x     = issue ? sel_x : '0;

   // round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall
   always_comb begin
      g_lo      = '0;
      g_hi      = '0;
      any_hi    = 1'b0;
      any_valid = |bus.req_valid;
      sel_x     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) g_lo = ID_W'(i);
         if (bus.req_valid[i] && ID_W'(i) >= rr_ptr) begin
            g_hi   = ID_W'(i);
            any_hi = 1'b1;
         end
      end
      grant = any_hi ? g_hi : g_lo;
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_ready[i] = issue && grant == ID_W'(i);
         if (grant == ID_W'(i)) sel_x = bus.req_x[i*TW +: TW];
      end
   end

   // pointer advances past the granted requester only when something issues
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr <= '0;
      else if (issue) rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
   end

   // tag pipe shifts every cycle so its last stage lines up with sin_y
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            tag_v[i]  <= 1'b0;
            tag_id[i] <= '0;
         end
      end else begin
         tag_v[0]  <= issue;
         tag_id[0] <= issue ? grant : '0;
         for (int i = 1; i < LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   // occupancy counters and FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         inflight   <= inflight + CW'(issue) - CW'(push);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
   end

   // FIFO storage needs no reset; rsp outputs are masked while empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_id[wr_ptr] <= tag_id[LAT-1];
         mem_y[wr_ptr]  <= bus.sin_y;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && fifo_count == CW'(FIFO_DEPTH)));

`ifdef SINE_ARB_STATS_EN
   // saturating issue and credit-stall counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (issue && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
         if (any_valid && !credit_ok && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_sine_unit_arbiter.sv
// tb_sine_unit_arbiter: random stimulus against a queue-based reference model with a decoupled response scoreboard
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module tb_sine_unit_arbiter;
   localparam int N_REQ      = 4;
   localparam int ID_W       = 2;
   localparam int LAT        = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int TW         = `TOTAL_WIDTH;

   typedef struct {
      int            id;
      logic [TW-1:0] y;
      int            due;
   } item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sine_unit_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .TW(TW)) bus ();

`ifdef SINE_ARB_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_stall;
`endif

   sine_unit_arbiter #(
      .N_REQ(N_REQ), .ID_W(ID_W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .TW(TW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef SINE_ARB_STATS_EN
      ,
      .stat_issued(stat_issued),
      .stat_stall(stat_stall)
`endif
   );

   // Piecewise-linear odd function standing in for the sine unit's arithmetic.
   function automatic logic [TW-1:0] sine_ref(input logic [TW-1:0] x);
      int v, a, y;
      v = int'($signed(x));
      a = v < 0 ? -v : v;
      y = a < 64 ? 3 * a : 192 + (a - 64) / 2;
      return TW'(v < 0 ? -y : y);
   endfunction

   // Sine unit: LAT register stages, not reset, so stale data keeps flowing through reset.
   logic [TW-1:0] sp [LAT];
   always @(posedge clk) begin
      sp[0] <= bus.sin_x;
      for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
   end
   assign bus.sin_y = sine_ref(sp[LAT-1]);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted request is an item due LAT+1 cycles later; items
   // leave in order once due and accepted; credit is "fewer than FIFO_DEPTH unretired items".
   item_t mq[$];
   item_t sb[$];
   item_t it;
   item_t mon_e;
   int    cyc = 0;
   int    rr = 0;
   int    g;
   int    exp_issued = 0;
   int    exp_stall = 0;
   bit    credit, issue, exp_busy, exp_rv;
   logic [N_REQ-1:0] exp_ready;
   logic [TW-1:0]    xin;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         sb.delete();
         rr = 0;
         exp_issued = 0;
         exp_stall = 0;
         check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
         check("rst_busy", 64'(bus.busy), 64'd0);
         check("rst_req_ready", 64'(bus.req_ready), 64'd0);
         check("rst_sin_x", 64'(bus.sin_x), 64'd0);
         check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
         check("rst_rsp_y", 64'(bus.rsp_y), 64'd0);
      end else begin
         exp_busy = mq.size() > 0;
         credit = mq.size() < FIFO_DEPTH;
         g = -1;
         for (int k = 0; k < N_REQ; k++)
            if (g < 0 && bus.req_valid[(rr + k) % N_REQ]) g = (rr + k) % N_REQ;
         issue = g >= 0 && credit;
         exp_ready = '0;
         if (issue) exp_ready[g] = 1'b1;
         check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
         if (issue) begin
            xin = bus.req_x[g*TW +: TW];
            check("sin_x", 64'(bus.sin_x), 64'(xin));
            it.id = g;
            it.y = sine_ref(xin);
            it.due = cyc + LAT + 1;
            mq.push_back(it);
            sb.push_back(it);
            rr = (g + 1) % N_REQ;
            exp_issued++;
         end else begin
            check("sin_x_idle", 64'(bus.sin_x), 64'd0);
         end
         if (g >= 0 && !credit) exp_stall++;
         exp_rv = mq.size() > 0 && mq[0].due <= cyc;
         check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
         check("busy", 64'(bus.busy), 64'(exp_busy));
         if (exp_rv && bus.rsp_ready) void'(mq.pop_front());
         cyc++;
      end
   end

   // Monitor: whenever the DUT hands over a response, it must match the oldest expected one.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d y %0h expected no response", bus.rsp_id, bus.rsp_y);
         end else begin
            mon_e = sb.pop_front();
            check("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
            check("rsp_y", 64'(bus.rsp_y), 64'(mon_e.y));
         end
      end
   end

   task automatic rand_x();
      for (int i = 0; i < N_REQ; i++) bus.req_x[i*TW +: TW] = TW'(int'($urandom_range(255)) - 128);
   endtask

   task automatic drive(input logic [N_REQ-1:0] v, input logic rdy, input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.req_valid = v;
         bus.rsp_ready = rdy;
         rand_x();
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_x = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // single request from lane 2 with x = 0
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0100;
      bus.req_x = '0;
      drive(4'b0000, 1'b1, 8);
      // all lanes continuously
      drive(4'b1111, 1'b1, 20);
      // lanes 0 and 3 only
      drive(4'b1001, 1'b1, 12);
      drive(4'b0000, 1'b1, 6);
      // backpressure then release
      drive(4'b1111, 1'b0, 10);
      drive(4'b1111, 1'b1, 15);
      drive(4'b0000, 1'b1, 8);
      // reset with tags in flight
      drive(4'b1111, 1'b1, 3);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(4'b0000, 1'b1, 8);
      // random traffic with random backpressure
      repeat (300) begin
         @(posedge clk);
         #1;
         bus.req_valid = N_REQ'($urandom);
         bus.rsp_ready = $urandom_range(3) != 0;
         rand_x();
      end
      drive(4'b0000, 1'b1, 20);
      @(negedge clk);
      check("all_responses_seen", 64'(sb.size()), 64'd0);
`ifdef SINE_ARB_STATS_EN
      check("stat_issued", 64'(stat_issued), 64'(exp_issued));
      check("stat_stall", 64'(stat_stall), 64'(exp_stall));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
